// File: rtl/slave_read_arbiter_pkg.sv
// Shared crossbar configuration: master/slave counts and the read-arbiter
// state encoding used by every per-slave arbiter instance.
package slave_read_arbiter_pkg;

  localparam int MASTER_NUM_DEFAULT = 4;
  localparam int SLAVE_NUM          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/slave_read_arbiter_rr_pick.sv
// Round-robin winner selection: the first set request bit found searching
// upward from last_idx+1, wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx
);

  logic          found;
  logic [IW-1:0] cand_idx;

  // Walk the N candidates in rotated priority order; the first hit wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = IW'((int'(last_idx) + k) % N);
      if (!found && req[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // One-hot form of the winner; all zero when nothing requests.
  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign pick[gi] = found && (pick_idx == IW'(gi));
  end

endmodule

// File: rtl/slave_read_arbiter.sv
// Per-slave read arbiter: grants one master at a time, holds the grant
// through the AR handshake and the whole R burst, then releases on the
// last beat. Only one read is outstanding per slave.
module slave_read_arbiter
  import slave_read_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = MASTER_NUM_DEFAULT,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MASTER_NUM-1:0] req,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  s_rlast,
  output logic [MASTER_NUM-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  ar_sel_valid,
  output logic                  busy
);

  arb_state_e            state_reg, state_next;
  logic [MASTER_NUM-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]      grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0]      last_idx_reg, last_idx_next;

  logic [MASTER_NUM-1:0] pick;
  logic [IDX_W-1:0]      pick_idx;

  rr_pick #(
    .N  (MASTER_NUM),
    .IW (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (last_idx_reg),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // State and grant registers; reset makes master 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      grant_idx_reg <= '0;
      last_idx_reg  <= IDX_W'(MASTER_NUM - 1);
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      last_idx_reg  <= last_idx_next;
    end
  end

  // Next-state logic: grant in IDLE, wait for AR accept, wait for last R beat.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    last_idx_next  = last_idx_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          grant_next     = pick;
          grant_idx_next = pick_idx;
          state_next     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Only the granted master's request matters; dropping it does not
        // release the grant, the arbiter simply keeps waiting.
        if (req[grant_idx_reg] && s_arready) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_rvalid && s_rready && s_rlast) begin
          last_idx_next  = grant_idx_reg;
          grant_next     = '0;
          grant_idx_next = '0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        grant_next     = '0;
        grant_idx_next = '0;
      end
    endcase
  end

  assign grant        = grant_reg;
  assign grant_idx    = grant_idx_reg;
  assign ar_sel_valid = (state_reg == ST_ADDR);
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_slave_read_arbiter.sv
// Bench for slave_read_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_slave_read_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         s_arready, s_rvalid, s_rready, s_rlast;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         ar_sel_valid, busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: phase 0 = no read pending, 1 = address pending, 2 = data pending.
  int m_phase;
  int m_owner;
  int m_last;
  int txn_count = 0;

  always #5 clk = ~clk;

  slave_read_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .s_arready    (s_arready),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .s_rlast      (s_rlast),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .ar_sel_valid (ar_sel_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = -1;
    m_last  = N - 1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int cand;
    case (m_phase)
      0: if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          cand = (m_last + k) % N;
          if (req[cand]) begin
            m_owner = cand;
            break;
          end
        end
        m_phase = 1;
      end
      1: if (req[m_owner] && s_arready) m_phase = 2;
      default: if (s_rvalid && s_rready && s_rlast) begin
        txn_count++;
        $display("[TB] txn %0d: master %0d read complete at %0t", txn_count, m_owner, $time);
        m_last  = m_owner;
        m_owner = -1;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] exp_grant;
    exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check("grant", 32'(grant), exp_grant);
    check("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("ar_sel_valid", 32'(ar_sel_valid), 32'(m_phase == 1));
    check("busy", 32'(busy), 32'(m_phase != 0));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_r(input logic v, input logic r, input logic l);
    s_rvalid = v;
    s_rready = r;
    s_rlast  = l;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    s_arready = 1'b0;
    set_r(1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Master 0 wins first out of 0101.
    req = 4'b0101;
    step();
    check("first_grant", 32'(grant), 32'h1);
    check("first_asv", 32'(ar_sel_valid), 32'h1);

    // Stalled AR with bit 3 toggling: grant must not move.
    for (int i = 0; i < 5; i++) begin
      req = (i % 2 == 0) ? 4'b1101 : 4'b0101;
      step();
    end
    check("stall_grant", 32'(grant), 32'h1);
    s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    check("to_data_asv", 32'(ar_sel_valid), 32'h0);
    check("to_data_busy", 32'(busy), 32'h1);

    // Four beats, second beat back-pressured, fourth is last.
    set_r(1'b1, 1'b1, 1'b0); step();
    set_r(1'b1, 1'b0, 1'b0); step();
    set_r(1'b1, 1'b1, 1'b0); step();
    set_r(1'b1, 1'b1, 1'b0); step();
    check("burst_hold", 32'(grant), 32'h1);
    set_r(1'b1, 1'b1, 1'b1); step();
    set_r(1'b0, 1'b0, 1'b0);
    check("burst_done_grant", 32'(grant), 32'h0);
    check("burst_done_busy", 32'(busy), 32'h0);

    // Round robin moves on to master 2.
    req = 4'b0101;
    step();
    check("rr_grant", 32'(grant), 32'h4);
    check("rr_idx", 32'(grant_idx), 32'd2);
    s_arready = 1'b1; step(); s_arready = 1'b0;
    set_r(1'b1, 1'b1, 1'b1); step(); set_r(1'b0, 1'b0, 1'b0);

    // Master 3 completes, then 1001 must wrap to master 0.
    req = 4'b1000; step();
    s_arready = 1'b1; step(); s_arready = 1'b0;
    set_r(1'b1, 1'b1, 1'b1); step(); set_r(1'b0, 1'b0, 1'b0);
    req = 4'b1001; step();
    check("wrap_grant", 32'(grant), 32'h1);
    s_arready = 1'b1; step(); s_arready = 1'b0;

    // Reset in DATA clears outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    req = 4'b1101;
    step();
    check("post_rst_grant", 32'(grant), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req       = N'($urandom_range(0, 15));
      s_arready = ($urandom_range(0, 3) != 0);
      s_rvalid  = ($urandom_range(0, 3) != 0);
      s_rready  = ($urandom_range(0, 3) != 0);
      s_rlast   = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/slave_read_arbiter.md
SLAVE_READ_ARBITER -- requirements
Module: slave_read_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 4, meaning number of upstream masters competing for this slave.
REQ-002 SHALL have parameter IDX_W, default $clog2(MASTER_NUM), meaning width of grant index.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  MASTER_NUM  per-master address-decode hit for this slave, pre-qualified with ARVALID.
REQ-006 SHALL have port s_arready  input  1  slave ARREADY.
REQ-007 SHALL have port s_rvalid, s_rready, s_rlast  input  1 each  slave R-channel handshake and last-beat flag.
REQ-008 SHALL have port grant  output  MASTER_NUM  one-hot selected master, zero when none.
REQ-009 SHALL have port grant_idx  output  IDX_W  binary index of grant, valid when grant nonzero.
REQ-010 SHALL have port ar_sel_valid  output  1  high while the arbiter is in ADDR, gating the AR mux valid toward the slave.
REQ-011 SHALL have port busy  output  1  high in ADDR or DATA.

Function
REQ-012 SHALL implement states IDLE, ADDR, DATA in a registered FSM.
REQ-013 IDLE: if req nonzero, SHALL register the winner into grant/grant_idx and enter ADDR next cycle; grant latency one cycle after req.
REQ-014 Winner SHALL be the first set req bit searching upward from (last_idx+1) modulo MASTER_NUM, wrapping past MASTER_NUM-1 to 0.
REQ-015 ADDR: SHALL hold grant unchanged and ar_sel_valid=1; on req[grant_idx] & s_arready SHALL enter DATA.
REQ-016 ADDR: req changes on non-granted bits SHALL be ignored; deassertion of req[grant_idx] SHALL not release grant.
REQ-017 DATA: SHALL hold grant, ar_sel_valid=0; on s_rvalid & s_rready & s_rlast SHALL set last_idx=grant_idx, clear grant, enter IDLE.
REQ-018 DATA: non-last R beats SHALL not change state; s_rvalid without s_rready SHALL not complete.
REQ-019 SHALL allow at most one outstanding read; new requests wait until IDLE.
REQ-020 Return to IDLE and new grant SHALL take separate cycles (one idle cycle minimum between transactions).
REQ-021 grant SHALL always be one-hot or zero; grant_idx SHALL equal encoding of grant.
REQ-022 last_idx wrap: with last_idx=MASTER_NUM-1, search SHALL begin at 0.

Reset
REQ-023 On rst_n low, SHALL asynchronously force state=IDLE, grant=0, grant_idx=0, ar_sel_valid=0, busy=0, last_idx=MASTER_NUM-1 (so master 0 wins first).
REQ-024 Reset mid-transaction SHALL abandon the transaction without completing it; first grant after release follows REQ-023 priority.

Structure
REQ-025 State enum and MASTER_NUM default SHALL live in the shared crossbar config package, alongside SLAVE_NUM.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_idx; outputs one-hot and index); FSM and registers stay in slave_read_arbiter.

Verification
REQ-027 Reset release, req=4'b0101 -> cycle+1 grant=4'b0001, grant_idx=0, ar_sel_valid=1.
REQ-028 After master 0 completes (s_rlast beat), req=4'b0101 held -> next grant=4'b0100, grant_idx=2.
REQ-029 In ADDR with s_arready=0 for 5 cycles, req toggling bit 3 -> grant stays 4'b0001, state ADDR; s_arready=1 -> DATA next cycle.
REQ-030 DATA with 4 beats, beat 2 has s_rready=0 and beat 4 s_rlast=1 -> grant cleared only after beat 4 handshake, busy falls same edge.
REQ-031 last_idx=3, req=4'b1001 -> grant=4'b0001 (wrap); reset asserted in DATA -> grant=0, busy=0 immediately, without waiting for a clock edge.
